// File: rtl/seq_restoring_divider_pkg.sv
// Shared types for the sequential restoring divider.
package seq_restoring_divider_pkg;

  // Controller states; encodings are fixed so that waveforms and other
  // blocks in the library decode them the same way.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// Ripple-borrow subtractor built from full adders: a - b = a + ~b + 1.

// One-bit full adder stage, the same cell used by the ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// N-bit subtractor; BORROW is high when b > a (no carry out of the top stage).
module n_bit_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] D,
  output logic         BORROW
);

  // Each stage owns its carry net so the chain is not one self-feeding vector.
  for (genvar i = 0; i < N; i++) begin : g_stage
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_first
      assign c_in = 1'b1;
    end else begin : g_rest
      assign c_in = g_stage[i-1].c_out;
    end

    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (c_in),
      .sum  (D[i]),
      .cout (c_out)
    );
  end

  assign BORROW = ~g_stage[N-1].c_out;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, separate result registers that hold between ops.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         START,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         BUSY,
  output logic         DONE,
  output logic         DIV0
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q;      // partial remainder
  logic [N-1:0]    qreg_q;   // dividend shifting out / quotient shifting in
  logic [N-1:0]    m_q;      // latched divisor
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    q_q, r_q;
  logic            div0_q;

  logic            accept;
  logic            last_iter;
  logic [N-1:0]    a_sh;
  logic [N:0]      diff;
  logic            sub_borrow;
  logic            restore;
  logic [N-1:0]    a_nx;
  logic [N-1:0]    q_nx;

  assign accept    = (state_q == S_IDLE) && START;
  assign last_iter = (cnt_q == '0);

  // Upper half of {A,Qreg} << 1; the vacated quotient bit is filled below.
  assign a_sh = {a_q[N-2:0], qreg_q[N-1]};

  // Widened by one bit so A' up to 2^N-1 never overflows the compare.
  n_bit_subtractor #(
    .N (N + 1)
  ) u_sub (
    .a      ({1'b0, a_sh}),
    .b      ({1'b0, m_q}),
    .D      (diff),
    .BORROW (sub_borrow)
  );

  // T[N] is the sign of the widened difference and always agrees with the
  // chain borrow for zero-extended operands.
  assign restore = diff[N] | sub_borrow;
  assign a_nx    = restore ? a_sh : diff[N-1:0];
  assign q_nx    = {qreg_q[N-2:0], ~restore};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: divide-by-zero skips straight to DONE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = (Y == '0) ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      qreg_q <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      div0_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      if (accept) begin
        if (Y == '0) begin
          q_q    <= '1;
          r_q    <= X;
          div0_q <= 1'b1;
        end else begin
          a_q    <= '0;
          qreg_q <= X;
          m_q    <= Y;
          cnt_q  <= CW'(N - 1);
          div0_q <= 1'b0;
        end
      end else if (state_q == S_CALC) begin
        a_q    <= a_nx;
        qreg_q <= q_nx;
        cnt_q  <= cnt_q - 1'b1;
        if (last_iter) begin
          q_q <= q_nx;
          r_q <= a_nx;
        end
      end
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign DIV0 = div0_q;
  assign BUSY = (state_q == S_CALC);
  assign DONE = (state_q == S_DONE);

endmodule
